// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game datapath blocks.
//   state_t        : bird FSM state encoding (IDLE, PLAY, DEAD)
//   *_DEF          : default geometry and motion parameters
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int ROWS_DEF     = 16;
  localparam int START_Y_DEF  = 7;
  localparam int FLAP_VEL_DEF = -3;
  localparam int MAX_FALL_DEF = 2;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input.
//   clk   : system clock
//   reset : synchronous, active-high reset (clears the history register)
//   in    : level input
//   rise  : high for the cycle where in=1 and in was 0 on the previous cycle
// The history register updates every cycle regardless of any pause state
// in the consumer.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= in;
  end

  assign rise = in & ~r_prev;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical motion and game-state FSM.
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   tick      : one-cycle game-speed enable
//   pause     : freezes position, velocity and state while high
//   flap      : debounced player button (level)
//   hit       : pipe collision flag (level)
//   bird_y    : current bird row, 0 = top, ROWS-1 = bottom (registered)
//   playing   : high in PLAY (registered)
//   game_over : high in DEAD (registered)
//
// state | meaning
// IDLE  | waiting for a flap to start, bird parked at START_Y
// PLAY  | bird moves on each tick, flaps queue one pending impulse
// DEAD  | ground crash or pipe hit, waiting for a flap to return to IDLE
module bird_motion
  import flappy_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int START_Y  = START_Y_DEF,
  parameter int FLAP_VEL = FLAP_VEL_DEF,
  parameter int MAX_FALL = MAX_FALL_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    pause,
  input  logic                    flap,
  input  logic                    hit,
  output logic [$clog2(ROWS)-1:0] bird_y,
  output logic                    playing,
  output logic                    game_over
);

  localparam int W  = $clog2(ROWS);
  // Signed working width: two bits above the row width covers the row range
  // plus negative overshoot, and never narrower than the 4-bit velocity.
  localparam int NW = (W + 2 > 5) ? W + 2 : 5;

  localparam logic [W-1:0]         L_START   = W'(START_Y);
  localparam logic [W-1:0]         L_BOTTOM  = W'(ROWS - 1);
  localparam logic signed [NW-1:0] L_MAXY    = NW'(ROWS - 1);
  localparam logic signed [NW-1:0] L_FLAP    = NW'(FLAP_VEL);
  localparam logic signed [NW-1:0] L_MAXF_N  = NW'(MAX_FALL);
  localparam logic signed [3:0]    L_MAXF_V  = 4'(MAX_FALL);

  state_t             r_state;
  logic [W-1:0]       r_bird_y;
  logic signed [3:0]  r_vel;
  logic               r_flap_pending;
  logic               r_playing;
  logic               r_game_over;

  logic                 w_rise;
  logic signed [NW-1:0] w_v;
  logic signed [NW-1:0] w_y_ext;
  logic signed [NW-1:0] w_n;
  logic signed [3:0]    w_vel_next;

  edge_detect u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .in    (flap),
    .rise  (w_rise)
  );

  assign w_v        = r_flap_pending ? L_FLAP : {{(NW-4){r_vel[3]}}, r_vel};
  assign w_y_ext    = {{(NW-W){1'b0}}, r_bird_y};
  assign w_n        = w_y_ext + w_v;
  // Gravity: one row/tick of acceleration, capped at MAX_FALL.
  assign w_vel_next = (w_v >= L_MAXF_N) ? L_MAXF_V : (w_v[3:0] + 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_bird_y       <= L_START;
      r_vel          <= '0;
      r_flap_pending <= 1'b0;
      r_playing      <= 1'b0;
      r_game_over    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise && !pause) begin
            r_state   <= PLAY;
            r_playing <= 1'b1;
          end
        end
        PLAY: begin
          if (pause) begin
            // Flaps still queue while paused; nothing else moves.
            if (w_rise) r_flap_pending <= 1'b1;
          end else if (hit) begin
            r_state     <= DEAD;
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end else if (tick) begin
            // A flap arriving with this tick is kept for the next one.
            r_flap_pending <= w_rise;
            if (w_n[NW-1]) begin
              r_bird_y <= '0;
              r_vel    <= '0;
            end else if (w_n > L_MAXY) begin
              r_bird_y    <= L_BOTTOM;
              r_state     <= DEAD;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
            end else begin
              r_bird_y <= w_n[W-1:0];
              r_vel    <= w_vel_next;
            end
          end else if (w_rise) begin
            r_flap_pending <= 1'b1;
          end
        end
        DEAD: begin
          if (w_rise && !pause) begin
            r_state        <= IDLE;
            r_bird_y       <= L_START;
            r_vel          <= '0;
            r_flap_pending <= 1'b0;
            r_game_over    <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_bird_y       <= L_START;
          r_vel          <= '0;
          r_flap_pending <= 1'b0;
          r_playing      <= 1'b0;
          r_game_over    <= 1'b0;
        end
      endcase
    end
  end

  assign bird_y    = r_bird_y;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_bird_motion.sv
module tb_bird_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       flap = 1'b0;
  logic       hit = 1'b0;
  logic [3:0] bird_y;
  logic       playing;
  logic       game_over;

  int vectors = 0;
  int errors  = 0;

  // Reference model: mode 0=waiting, 1=flying, 2=crashed.
  int m_mode = 0;
  int m_y    = 7;
  int m_vel  = 0;
  bit m_pend = 0;
  bit m_prev = 0;

  bird_motion dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .pause     (pause),
    .flap      (flap),
    .hit       (hit),
    .bird_y    (bird_y),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic model_update(input bit r, input bit t, input bit p, input bit f, input bit h);
    bit rise;
    int v, n;
    rise = f && !m_prev;
    m_prev = r ? 1'b0 : f;
    if (r) begin
      m_mode = 0; m_y = 7; m_vel = 0; m_pend = 0;
    end else if (m_mode == 0) begin
      if (rise && !p) m_mode = 1;
    end else if (m_mode == 1) begin
      if (p) begin
        if (rise) m_pend = 1;
      end else if (h) begin
        m_mode = 2;
      end else if (t) begin
        v = m_pend ? -3 : m_vel;
        n = m_y + v;
        m_pend = rise;
        if (n < 0) begin
          m_y = 0; m_vel = 0;
        end else if (n > 15) begin
          m_y = 15; m_mode = 2;
        end else begin
          m_y = n;
          m_vel = (v + 1 > 2) ? 2 : v + 1;
        end
      end else if (rise) begin
        m_pend = 1;
      end
    end else begin
      if (rise && !p) begin
        m_mode = 0; m_y = 7; m_vel = 0; m_pend = 0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input bit t, input bit p, input bit f, input bit h);
    reset = r; tick = t; pause = p; flap = f; hit = h;
    model_update(r, t, p, f, h);
    @(posedge clk);
    #1;
    vectors++;
    if (bird_y !== 4'(m_y) || playing !== (m_mode == 1) || game_over !== (m_mode == 2)) begin
      errors++;
      $display("FAIL model_cmp t=%0t: got y=%0d play=%b over=%b, want y=%0d play=%b over=%b",
               $time, bird_y, playing, game_over, m_y, (m_mode == 1), (m_mode == 2));
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic start_game();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
  endtask

  int exp_fall[6] = '{7, 8, 10, 12, 14, 15};

  initial begin
    // Reset
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    check_lit("reset_y", int'(bird_y), 7);
    check_lit("reset_playing", int'(playing), 0);
    check_lit("reset_over", int'(game_over), 0);

    // Ticks ignored in IDLE
    step(0, 1, 0, 0, 0);
    check_lit("idle_tick_y", int'(bird_y), 7);

    // Free fall to the ground
    start_game();
    check_lit("start_playing", int'(playing), 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0);
      check_lit($sformatf("fall_y%0d", i), int'(bird_y), exp_fall[i]);
    end
    check_lit("fall_over", int'(game_over), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check_lit("dead_to_idle_y", int'(bird_y), 7);
    check_lit("dead_to_idle_play", int'(playing), 0);

    // Flap, then ceiling clamp
    start_game();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_lit("flap_y1", int'(bird_y), 4);
    step(0, 1, 0, 0, 0);
    check_lit("flap_y2", int'(bird_y), 2);
    step(0, 1, 0, 0, 0);
    check_lit("flap_y3", int'(bird_y), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_lit("ceil_y", int'(bird_y), 0);
    check_lit("ceil_play", int'(playing), 1);
    step(0, 1, 0, 0, 0);
    check_lit("ceil_vel0", int'(bird_y), 0);

    // Flap on the same cycle as a tick is deferred to the next tick
    step(1, 0, 0, 0, 0);
    start_game();
    step(0, 1, 0, 1, 0);
    check_lit("defer_y1", int'(bird_y), 7);
    step(0, 1, 0, 0, 0);
    check_lit("defer_y2", int'(bird_y), 4);

    // Pause
    step(1, 0, 0, 0, 0);
    start_game();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, (i == 2), (i == 3));
      step(0, 0, 1, 0, 0);
    end
    check_lit("pause_y", int'(bird_y), 8);
    check_lit("pause_play", int'(playing), 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_lit("pause_flap_y", int'(bird_y), 5);

    // Hit with tick at row 9
    step(1, 0, 0, 0, 0);
    start_game();
    for (int i = 0; i < 40 && m_y != 9; i++) begin
      if (m_y > 9) begin
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
      end else begin
        step(0, 1, 0, 0, 0);
      end
    end
    check_lit("reach9_y", int'(bird_y), 9);
    check_lit("reach9_play", int'(playing), 1);
    step(0, 1, 0, 0, 1);
    check_lit("hit_y", int'(bird_y), 9);
    check_lit("hit_over", int'(game_over), 1);
    step(0, 1, 0, 0, 0);
    check_lit("dead_hold_y", int'(bird_y), 9);
    step(0, 0, 0, 1, 0);
    check_lit("hit_idle_y", int'(bird_y), 7);
    check_lit("hit_idle_over", int'(game_over), 0);

    // Reset in the middle of play at row 12
    step(0, 0, 0, 0, 0);
    start_game();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    check_lit("pre_rst_y", int'(bird_y), 12);
    step(1, 1, 0, 1, 1);
    check_lit("rst_play_y", int'(bird_y), 7);
    check_lit("rst_play_play", int'(playing), 0);
    check_lit("rst_play_over", int'(game_over), 0);

    // Randomised run against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
